// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word memory behind a valid/ready request
// channel with a one-cycle response strobe and fault flagging.
// Ports: clk, rst (sync, active-low); req_valid, req_write, Address,
//        WriteData, ByteEn in; req_ready, resp_valid, ReadData,
//        resp_err, busy out.
module dmem_responder #(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [3:0]  ByteEn,
    output logic        resp_valid,
    output logic [31:0] ReadData,
    output logic        resp_err,
    output logic        busy
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        write_q, write_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [MEM_DEPTH];

    logic [31:0]   eff_addr;
    logic [31:0]   eff_wdata;
    logic [3:0]    eff_be;
    logic          eff_write;
    logic          fault;
    logic          commit;
    logic          do_write;
    logic [AW-1:0] idx;

    // In IDLE the live inputs are used so a zero-wait access can
    // commit on its accepting edge; otherwise the captured copies.
    always_comb begin
        if (state_q == IDLE) begin
            eff_addr  = Address;
            eff_wdata = WriteData;
            eff_be    = ByteEn;
            eff_write = req_write;
        end else begin
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_be    = be_q;
            eff_write = write_q;
        end
    end

    assign idx   = eff_addr[AW+1:2];
    assign fault = (eff_addr[1:0] != 2'b00) ||
                   ({2'b00, eff_addr[31:2]} >= 32'(MEM_DEPTH));

    // The edge that enters RESP is the one that reads or writes storage.
    assign commit = ((state_q == IDLE) && req_valid && (WAIT_INIT == 4'd0)) ||
                    ((state_q == WAIT) && (cnt_q == 4'd1));
    assign do_write = rst && commit && eff_write && !fault;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = Address;
                    wdata_d = WriteData;
                    be_d    = ByteEn;
                    write_d = req_write;
                    if (WAIT_INIT == 4'd0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (commit) begin
            err_d   = fault;
            rdata_d = (!fault && !eff_write) ? mem[idx] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            write_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_be[b]) begin
                    mem[idx][8*b +: 8] <= eff_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign ReadData   = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder,
// one instance with two wait cycles and one with zero.
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int WC    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_valid, a_ready, a_write, a_rv, a_err, a_busy;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;

    logic        z_valid, z_ready, z_write, z_rv, z_err, z_busy;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [3:0]  z_be;

    dmem_responder #(.MEM_DEPTH(DEPTH), .WAIT_CYCLES(WC)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .Address(a_addr), .WriteData(a_wdata), .ByteEn(a_be),
        .resp_valid(a_rv), .ReadData(a_rdata), .resp_err(a_err),
        .busy(a_busy)
    );

    dmem_responder #(.MEM_DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_z (
        .clk(clk), .rst(rst),
        .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
        .Address(z_addr), .WriteData(z_wdata), .ByteEn(z_be),
        .resp_valid(z_rv), .ReadData(z_rdata), .resp_err(z_err),
        .busy(z_busy)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
        int          acc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_z[$];
    logic [31:0] model [int];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor for the wait-stated instance.
    logic        hold_pending = 1'b0;
    logic [31:0] last_rd;
    logic        last_err;
    always @(negedge clk) begin
        exp_t e;
        if (rst && a_rv) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_resp", {31'b0, a_rv}, 32'h0);
            end else begin
                e = q_a.pop_front();
                check("a_resp_err", {31'b0, a_err}, {31'b0, e.err});
                if (e.chk) check("a_rdata", a_rdata, e.rdata);
                check("a_latency", 32'(cyc - e.acc), 32'(WC + 1));
                check("a_busy_in_resp", {31'b0, a_busy}, 32'h1);
                check("a_ready_in_resp", {31'b0, a_ready}, 32'h0);
            end
            hold_pending <= 1'b1;
            last_rd      <= a_rdata;
            last_err     <= a_err;
        end else if (rst && hold_pending) begin
            hold_pending <= 1'b0;
            check("a_rdata_hold", a_rdata, last_rd);
            check("a_err_hold", {31'b0, a_err}, {31'b0, last_err});
            check("a_ready_after", {31'b0, a_ready}, 32'h1);
        end else begin
            hold_pending <= 1'b0;
        end
    end

    // Monitor for the zero-wait instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst && z_rv) begin
            if (q_z.size() == 0) begin
                check("z_unexpected_resp", {31'b0, z_rv}, 32'h0);
            end else begin
                e = q_z.pop_front();
                check("z_resp_err", {31'b0, z_err}, {31'b0, e.err});
                if (e.chk) check("z_rdata", z_rdata, e.rdata);
                check("z_latency", 32'(cyc - e.acc), 32'h1);
            end
        end
    end

    task automatic issue_a(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        int idx;
        int guard;
        logic [31:0] w;
        @(negedge clk);
        a_valid = 1'b1;
        a_write = wr;
        a_addr  = addr;
        a_wdata = wd;
        a_be    = be;
        guard   = 0;
        while (!a_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!a_ready) begin
            check("a_accept_timeout", {31'b0, a_ready}, 32'h1);
            a_valid = 1'b0;
            return;
        end
        e.acc   = cyc;
        e.chk   = 1'b1;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if (addr[1:0] != 2'b00 || addr[31:2] >= DEPTH) begin
            e.err = 1'b1;
        end else begin
            idx = int'(addr[31:2]);
            if (wr) begin
                if (model.exists(idx) || be == 4'hF) begin
                    w = model.exists(idx) ? model[idx] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
                    model[idx] = w;
                end
            end else if (model.exists(idx)) begin
                e.rdata = model[idx];
            end else begin
                e.chk = 1'b0;
            end
        end
        q_a.push_back(e);
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((q_a.size() != 0 || q_z.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check(name, 32'(q_a.size() + q_z.size()), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int guard;
        int n;
        int k;
        int sel;
        int widx;
        logic [31:0] addr;
        logic [31:0] zval;

        rst = 1'b0;
        a_valid = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_be = 0;
        z_valid = 0; z_write = 0; z_addr = 0; z_wdata = 0; z_be = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, a_ready}, 32'h1);
        check("rst_resp_valid", {31'b0, a_rv}, 32'h0);
        check("rst_rdata", a_rdata, 32'h0);
        check("rst_err", {31'b0, a_err}, 32'h0);
        check("rst_busy", {31'b0, a_busy}, 32'h0);
        rst = 1'b1;

        for (int i = 0; i <= 17; i++)
            issue_a(1'b1, 32'((i == 17 ? 1023 : i) << 2), $urandom, 4'hF);

        issue_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue_a(1'b0, 32'h10, 32'h0, 4'h0);
        issue_a(1'b1, 32'h40, 32'h11223344, 4'hF);
        issue_a(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101);
        issue_a(1'b0, 32'h40, 32'h0, 4'h0);
        drain("drain_directed");
        check("byte_enable_model", model[16], 32'h11BB33DD);

        issue_a(1'b0, 32'h12, 32'h0, 4'h0);
        issue_a(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF);
        issue_a(1'b0, 32'h0, 32'h0, 4'h0);
        issue_a(1'b0, 32'hFFC, 32'h0, 4'h0);
        issue_a(1'b1, 32'h0, 32'h0BADF00D, 4'h0);
        issue_a(1'b0, 32'h0, 32'h0, 4'h0);

        for (int i = 0; i < 150; i++) begin
            sel  = $urandom_range(0, 9);
            k    = $urandom_range(0, 17);
            widx = (k == 17) ? 1023 : k;
            if (sel <= 6)
                addr = 32'(widx << 2);
            else if (sel == 7)
                addr = 32'(widx << 2) | 32'($urandom_range(1, 3));
            else if (sel == 8)
                addr = 32'((DEPTH + $urandom_range(0, 100000)) << 2);
            else
                addr = $urandom_range(0, 1) ? 32'hFFC : 32'h1000;
            issue_a(1'($urandom_range(0, 1)), addr, $urandom,
                    4'($urandom_range(0, 15)));
        end
        drain("drain_random");

        // Reset lands on the edge that would commit the store.
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h20;
        a_wdata = 32'h12345678; a_be = 4'hF;
        guard = 0;
        while (!a_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("rst_store_accept", {31'b0, a_ready}, 32'h1);
        @(posedge clk);
        #1 a_valid = 1'b0;
        repeat (WC - 1) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", {31'b0, a_ready}, 32'h1);
        check("midrst_busy", {31'b0, a_busy}, 32'h0);
        check("midrst_rdata", a_rdata, 32'h0);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("midrst_no_resp", {31'b0, a_rv}, 32'h0);
        end
        issue_a(1'b0, 32'h20, 32'h0, 4'h0);
        drain("drain_midrst");

        // Zero-wait instance: seed word 0, then hold req_valid for 3 loads.
        zval = $urandom;
        @(negedge clk);
        z_valid = 1'b1; z_write = 1'b1; z_addr = 32'h0;
        z_wdata = zval; z_be = 4'hF;
        guard = 0;
        while (!z_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("z_store_accept", {31'b0, z_ready}, 32'h1);
        e.acc = cyc; e.chk = 1'b1; e.rdata = 32'h0; e.err = 1'b0;
        q_z.push_back(e);
        @(posedge clk);
        #1 z_valid = 1'b0;
        @(negedge clk);
        z_valid = 1'b1; z_write = 1'b0; z_addr = 32'h0;
        guard = 0;
        while (!z_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n = 0;
        k = 0;
        while (n < 3 && k < 20) begin
            check("z_ready_alternates", {31'b0, z_ready},
                  {31'b0, (k % 2) == 0});
            if (z_ready) begin
                e.acc = cyc; e.chk = 1'b1; e.rdata = zval; e.err = 1'b0;
                q_z.push_back(e);
                n++;
            end
            k++;
            if (n == 3) begin
                @(posedge clk);
                #1 z_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check("z_loads_issued", 32'(n), 32'h3);
        drain("drain_zero_wait");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
